// File: rtl/data_ram_write_arbiter_pkg.sv
// rtl/data_ram_write_arbiter_pkg.sv - shared defaults and grant encoding for the data RAM write arbiter
package data_ram_write_arbiter_pkg;

  localparam int ARB_DATA_WIDTH   = 16;
  localparam int ARB_ADDR_WIDTH   = 8;
  localparam int ARB_QUEUE_DEPTH  = 4;
  localparam int ARB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CORE,
    GRANT_DBG
  } grant_e;

endpackage

// File: rtl/data_ram_write_arbiter_if.sv
// rtl/data_ram_write_arbiter_if.sv - core writeback, debug request and RAM write signals of the arbiter
interface data_ram_write_arbiter_if
  import data_ram_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH  = ARB_ADDR_WIDTH,
  parameter int QUEUE_DEPTH = ARB_QUEUE_DEPTH
);

  logic                           iCoreWriteEnable;
  logic [ADDR_WIDTH-1:0]          iCoreWriteAddress;
  logic [DATA_WIDTH-1:0]          iCoreDataIn;
  logic                           oCoreStall;
  logic                           iDbgValid;
  logic [ADDR_WIDTH-1:0]          iDbgAddress;
  logic [DATA_WIDTH-1:0]          iDbgData;
  logic                           oDbgReady;
  logic                           oRamWriteEnable;
  logic [ADDR_WIDTH-1:0]          oRamWriteAddress;
  logic [DATA_WIDTH-1:0]          oRamDataIn;
  logic [$clog2(QUEUE_DEPTH):0]   oQueueLevel;

  modport master (
    output iCoreWriteEnable, iCoreWriteAddress, iCoreDataIn,
    output iDbgValid, iDbgAddress, iDbgData,
    input  oCoreStall, oDbgReady, oRamWriteEnable, oRamWriteAddress, oRamDataIn, oQueueLevel
  );

  modport slave (
    input  iCoreWriteEnable, iCoreWriteAddress, iCoreDataIn,
    input  iDbgValid, iDbgAddress, iDbgData,
    output oCoreStall, oDbgReady, oRamWriteEnable, oRamWriteAddress, oRamDataIn, oQueueLevel
  );

endinterface

// File: rtl/data_ram_write_arbiter_write_queue_fifo.sv
// rtl/data_ram_write_arbiter_write_queue_fifo.sv - synchronous FIFO holding queued {address, data} debug writes
module write_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_ONE  = (PW+1)'(1);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_level == LVL_FULL);
  assign o_empty     = (r_level == '0);
  assign o_level     = r_level;
  assign o_head_data = r_mem[r_head];
  assign w_do_push   = i_push & ~o_full;
  assign w_do_pop    = i_pop & ~o_empty;

  // Pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_do_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/data_ram_write_arbiter.sv
// rtl/data_ram_write_arbiter.sv - shares the data RAM write port between core writeback and queued debug writes
module data_ram_write_arbiter
  import data_ram_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
  parameter int QUEUE_DEPTH  = ARB_QUEUE_DEPTH,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                   Clock,
  input  logic                   Reset,
  data_ram_write_arbiter_if.slave bus
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]                 r_starve;
  logic [EW-1:0]                 w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(QUEUE_DEPTH):0]  w_level;
  logic                          w_stall;
  logic                          w_dbg_ready;
  logic                          w_push;
  logic                          w_pop;
  grant_e                        w_grant;

  write_queue_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_push      (w_push),
    .i_push_data ({bus.iDbgAddress, bus.iDbgData}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // Ready and stall depend only on registered state (plus Reset), never on request inputs
  assign w_dbg_ready = ~w_full & ~Reset;
  assign w_stall     = (r_starve == STARVE_MAX) & ~w_empty & ~Reset;
  assign w_push      = bus.iDbgValid & w_dbg_ready;
  assign w_pop       = (w_grant == GRANT_DBG);

  always_comb begin
    w_grant = GRANT_NONE;
    if (Reset)                       w_grant = GRANT_NONE;
    else if (w_stall)                w_grant = GRANT_DBG;
    else if (w_empty)                w_grant = GRANT_CORE;
    else if (!bus.iCoreWriteEnable)  w_grant = GRANT_DBG;
    else                             w_grant = GRANT_CORE;
  end

  assign bus.oRamWriteEnable  = (w_grant == GRANT_DBG) |
                                ((w_grant == GRANT_CORE) & bus.iCoreWriteEnable);
  assign bus.oRamWriteAddress = (w_grant == GRANT_DBG) ? w_head[EW-1 -: ADDR_WIDTH]
                                                       : bus.iCoreWriteAddress;
  assign bus.oRamDataIn       = (w_grant == GRANT_DBG) ? w_head[DATA_WIDTH-1:0]
                                                       : bus.iCoreDataIn;
  assign bus.oCoreStall       = w_stall;
  assign bus.oDbgReady        = w_dbg_ready;
  assign bus.oQueueLevel      = w_level;

  // Counts core grants taken while debug work is waiting
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_starve <= '0;
    end else if (w_grant != GRANT_CORE || w_empty) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_ram_write_arbiter.sv
// tb/tb_data_ram_write_arbiter.sv - scoreboard bench for the data RAM write arbiter
module tb_data_ram_write_arbiter;

  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  logic [23:0] exp_q[$];
  logic [15:0] ram_model [256];

  data_ram_write_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .QUEUE_DEPTH(4)) bus ();

  data_ram_write_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .QUEUE_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every RAM write must match the next scoreboard entry
  always @(negedge Clock) begin
    if (bus.oRamWriteEnable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ram_write: got unexpected %h=%h want none",
                 bus.oRamWriteAddress, bus.oRamDataIn);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({bus.oRamWriteAddress, bus.oRamDataIn} !== e) begin
          bad++;
          $display("FAIL ram_write: got %h=%h want %h=%h",
                   bus.oRamWriteAddress, bus.oRamDataIn, e[23:16], e[15:0]);
        end
      end
      ram_model[bus.oRamWriteAddress] = bus.oRamDataIn;
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic core(input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.iCoreWriteEnable  = we;
    bus.iCoreWriteAddress = a;
    bus.iCoreDataIn       = d;
  endtask

  task automatic dbg(input logic v, input logic [7:0] a, input logic [15:0] d);
    bus.iDbgValid   = v;
    bus.iDbgAddress = a;
    bus.iDbgData    = d;
  endtask

  // Core writes every cycle while one debug write waits; stall lands on cycle 9
  task automatic starve_run(input logic [7:0] base, input logic [7:0] da, input logic [15:0] dd,
                            input logic [7:0] ha, input logic [15:0] hd);
    for (int i = 0; i < 9; i++) begin
      cyc();
      core(1'b1, base + 8'(i), 16'h1000 + 16'(i));
      if (i == 0) dbg(1'b1, da, dd);
      else        dbg(1'b0, 8'h00, 16'h0000);
      exp_q.push_back({base + 8'(i), 16'h1000 + 16'(i)});
      @(negedge Clock);
      chk($sformatf("stall_off_%0d", i), bus.oCoreStall, 1'b0);
    end
    cyc();
    core(1'b1, ha, hd);
    exp_q.push_back({da, dd});
    @(negedge Clock);
    chk("stall_on", bus.oCoreStall, 1'b1);
    chk("stall_level", bus.oQueueLevel, 3'd1);
    cyc();
    exp_q.push_back({ha, hd});
    @(negedge Clock);
    chk("stall_once", bus.oCoreStall, 1'b0);
    chk("after_stall_level", bus.oQueueLevel, 3'd0);
    cyc();
    core(1'b0, 8'h00, 16'h0000);
  endtask

  initial begin
    Reset = 1'b1;
    core(1'b1, 8'h99, 16'hDEAD);
    dbg(1'b0, 8'h00, 16'h0000);

    // Reset state: no write, no ready, no stall
    cyc();
    @(negedge Clock);
    chk("rst_we", bus.oRamWriteEnable, 1'b0);
    chk("rst_ready", bus.oDbgReady, 1'b0);
    chk("rst_stall", bus.oCoreStall, 1'b0);
    cyc();

    // Core write with empty queue goes straight through
    Reset = 1'b0;
    core(1'b1, 8'h05, 16'h1234);
    exp_q.push_back({8'h05, 16'h1234});
    @(negedge Clock);
    chk("t1_stall", bus.oCoreStall, 1'b0);
    chk("t1_level", bus.oQueueLevel, 3'd0);
    chk("t1_ready", bus.oDbgReady, 1'b1);

    // Debug writes with idle core, one cycle latency each
    cyc();
    core(1'b0, 8'h00, 16'h0000);
    dbg(1'b1, 8'h10, 16'hAAAA);
    exp_q.push_back({8'h10, 16'hAAAA});
    @(negedge Clock);
    chk("t2_level_a", bus.oQueueLevel, 3'd0);
    cyc();
    dbg(1'b1, 8'h11, 16'hBBBB);
    exp_q.push_back({8'h11, 16'hBBBB});
    @(negedge Clock);
    chk("t2_level_b", bus.oQueueLevel, 3'd1);
    cyc();
    dbg(1'b0, 8'h00, 16'h0000);
    @(negedge Clock);
    chk("t2_level_pushpop", bus.oQueueLevel, 3'd1);
    cyc();
    @(negedge Clock);
    chk("t2_level_end", bus.oQueueLevel, 3'd0);

    // Starvation guard
    starve_run(8'h30, 8'h40, 16'hCAFE, 8'h39, 16'h1009);

    // Queue fill while core busy; 5th offer waits for the forced pop
    for (int c = 0; c < 12; c++) begin
      int ck;
      ck = (c <= 9) ? c : c - 1;
      cyc();
      core(1'b1, 8'h50 + 8'(ck), 16'h2000 + 16'(ck));
      if (c < 4)        dbg(1'b1, 8'h60 + 8'(c), 16'h3000 + 16'(c));
      else if (c < 11)  dbg(1'b1, 8'h64, 16'h3004);
      else              dbg(1'b0, 8'h00, 16'h0000);
      if (c == 9) exp_q.push_back({8'h60, 16'h3000});
      else        exp_q.push_back({8'h50 + 8'(ck), 16'h2000 + 16'(ck)});
      @(negedge Clock);
      if (c == 3)  chk("t4_ready_3", bus.oDbgReady, 1'b1);
      if (c == 4) begin
        chk("t4_full_ready", bus.oDbgReady, 1'b0);
        chk("t4_full_level", bus.oQueueLevel, 3'd4);
      end
      if (c == 9) begin
        chk("t4_stall", bus.oCoreStall, 1'b1);
        chk("t4_stall_ready", bus.oDbgReady, 1'b0);
      end
      if (c == 10) begin
        chk("t4_pop_ready", bus.oDbgReady, 1'b1);
        chk("t4_pop_level", bus.oQueueLevel, 3'd3);
      end
      if (c == 11) begin
        chk("t4_refill_level", bus.oQueueLevel, 3'd4);
        chk("t4_refill_ready", bus.oDbgReady, 1'b0);
      end
    end
    cyc();
    core(1'b0, 8'h00, 16'h0000);
    exp_q.push_back({8'h61, 16'h3001});
    @(negedge Clock);
    chk("t4_drain_level", bus.oQueueLevel, 3'd4);

    // Reset with 3 queued entries flushes them
    cyc();
    Reset = 1'b1;
    @(negedge Clock);
    chk("t5_rst_level", bus.oQueueLevel, 3'd3);
    chk("t5_rst_ready", bus.oDbgReady, 1'b0);
    chk("t5_rst_we", bus.oRamWriteEnable, 1'b0);
    cyc();
    Reset = 1'b0;
    @(negedge Clock);
    chk("t5_ready_back", bus.oDbgReady, 1'b1);
    chk("t5_level", bus.oQueueLevel, 3'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge Clock);
      chk("t5_idle_level", bus.oQueueLevel, 3'd0);
    end

    // Same address: forced debug write first, core overwrites next cycle
    starve_run(8'h70, 8'h20, 16'hD00D, 8'h20, 16'h5A5A);
    cyc();
    @(negedge Clock);
    chk("t6_last_write_wins", ram_model[8'h20], 16'h5A5A);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
